// File: rtl/param_fifo_if.sv
// Write/read handshake bundle for param_fifo. The slave modport is the FIFO side.
// A transfer happens on a rising edge where *_enable and the matching *_ready are both high;
// ready never depends on enable, and read_data is valid whenever read_ready is high.
interface param_fifo_if #(
    parameter int WIDTH = 8
);
    logic             write_enable;
    logic [WIDTH-1:0] write_data;
    logic             write_ready;
    logic             read_enable;
    logic             read_ready;
    logic [WIDTH-1:0] read_data;

    modport master (
        output write_enable, write_data, read_enable,
        input  write_ready, read_ready, read_data
    );

    modport slave (
        input  write_enable, write_data, read_enable,
        output write_ready, read_ready, read_data
    );
endinterface

// File: rtl/param_fifo.sv
// Parametrised first-word-fall-through FIFO with occupancy count, almost flags,
// synchronous clear and sticky overflow/underflow flags.
module param_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   clear,
    param_fifo_if.slave            bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             not_full, not_empty;
    logic             wr_accept, rd_accept;

    assign not_full  = (count_q != CW'(DEPTH));
    assign not_empty = (count_q != '0);

    // A full FIFO refuses writes even when a read frees a slot in the same cycle.
    assign wr_accept = bus.write_enable & not_full & ~clear;
    assign rd_accept = bus.read_enable & not_empty & ~clear;

    assign bus.write_ready = not_full;
    assign bus.read_ready  = not_empty;
    assign bus.read_data   = not_empty ? mem_q[rd_ptr_q] : '0;

    assign count        = count_q;
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_accept) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q | (bus.write_enable & ~not_full);
            underflow_d = underflow_q | (bus.read_enable & ~not_empty);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; read_data is masked while empty.
    always_ff @(posedge CLK) begin
        if (wr_accept) mem_q[wr_ptr_q] <= bus.write_data;
    end
endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo (WIDTH=8, DEPTH=4): vector table plus hand-written
// wrap-around and asynchronous-reset sequences.
module tb_param_fifo;
    logic       CLK = 1'b0;
    logic       RST;
    logic       clear;
    logic [2:0] count;
    logic       almost_full, almost_empty, overflow, underflow;

    param_fifo_if #(.WIDTH(8)) bus ();

    param_fifo #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .clear        (clear),
        .bus          (bus.slave),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       clr;
        logic [2:0] cnt;
        logic [7:0] rd;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [7:0] wd, input logic re, input logic clr,
                       input logic [2:0] cnt, input logic [7:0] rd, input logic ov, input logic un);
        vec_t v;
        v.we = we; v.wd = wd; v.re = re; v.clr = clr;
        v.cnt = cnt; v.rd = rd; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic we, input logic [7:0] wd, input logic re, input logic clr);
        bus.write_enable = we;
        bus.write_data   = wd;
        bus.read_enable  = re;
        clear            = clr;
    endtask

    // Advance one edge and land 1 time unit after it, away from the active edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Checks every output against an expected count; flags follow DEPTH=4, AF=3, AE=1.
    task automatic chk_state(input string tag, input logic [2:0] cnt, input logic [7:0] rd,
                             input logic ov, input logic un);
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " read_data"}, 32'(bus.read_data), 32'(rd));
        chk({tag, " write_ready"}, 32'(bus.write_ready), 32'(cnt != 3'd4));
        chk({tag, " read_ready"}, 32'(bus.read_ready), 32'(cnt != 3'd0));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(cnt >= 3'd3));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 3'd1));
        chk({tag, " overflow"}, 32'(overflow), 32'(ov));
        chk({tag, " underflow"}, 32'(underflow), 32'(un));
    endtask

    initial begin
        //   we  wd     re clr  cnt  rd     ov un
        add(1, 8'h11, 0, 0,  3'd1, 8'h11, 0, 0);
        add(1, 8'h22, 0, 0,  3'd2, 8'h11, 0, 0);
        add(1, 8'h33, 0, 0,  3'd3, 8'h11, 0, 0);
        add(1, 8'h44, 0, 0,  3'd4, 8'h11, 0, 0);
        add(1, 8'h55, 0, 0,  3'd4, 8'h11, 1, 0);
        add(0, 8'h00, 1, 0,  3'd3, 8'h22, 1, 0);
        add(0, 8'h00, 1, 0,  3'd2, 8'h33, 1, 0);
        add(0, 8'h00, 1, 0,  3'd1, 8'h44, 1, 0);
        add(0, 8'h00, 1, 0,  3'd0, 8'h00, 1, 0);
        add(1, 8'h01, 0, 0,  3'd1, 8'h01, 1, 0);
        add(1, 8'h02, 0, 0,  3'd2, 8'h01, 1, 0);
        add(1, 8'hA0, 1, 0,  3'd2, 8'h02, 1, 0);
        add(0, 8'h00, 1, 0,  3'd1, 8'hA0, 1, 0);
        add(0, 8'h00, 1, 0,  3'd0, 8'h00, 1, 0);
        add(1, 8'h5A, 1, 0,  3'd1, 8'h5A, 1, 1);
        add(1, 8'h6B, 0, 0,  3'd2, 8'h5A, 1, 1);
        add(1, 8'h7C, 0, 0,  3'd3, 8'h5A, 1, 1);
        add(1, 8'h8D, 0, 0,  3'd4, 8'h5A, 1, 1);
        add(1, 8'h9E, 1, 0,  3'd3, 8'h6B, 1, 1);
        add(1, 8'hFF, 0, 1,  3'd0, 8'h00, 0, 0);
        add(0, 8'h00, 1, 0,  3'd0, 8'h00, 0, 1);
        add(0, 8'h00, 1, 1,  3'd0, 8'h00, 0, 0);
        add(1, 8'h13, 0, 0,  3'd1, 8'h13, 0, 0);
        add(0, 8'h00, 1, 0,  3'd0, 8'h00, 0, 0);

        RST = 1'b1;
        drive(0, 8'h00, 0, 0);
        #3 RST = 1'b0;
        #1 chk_state("reset", 3'd0, 8'h00, 0, 0);
        step();
        step();
        RST = 1'b1;
        step();
        chk_state("post_reset", 3'd0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].clr);
            step();
            chk_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].rd, vecs[i].ov, vecs[i].un);
        end

        // Wrap-around: keep two entries resident while 10 write/read pairs stream through.
        for (int i = 0; i < 2; i++) begin
            drive(1, 8'h30 + 8'(i), 0, 0);
            exp_q.push_back(8'h30 + 8'(i));
            step();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'h40 + 8'(i), 1, 0);
            chk($sformatf("wrap%0d read_data", i), 32'(bus.read_data), 32'(exp_q.pop_front()));
            exp_q.push_back(8'h40 + 8'(i));
            step();
            chk($sformatf("wrap%0d count", i), 32'(count), 32'd2);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 8'h00, 1, 0);
            chk($sformatf("drain%0d read_data", i), 32'(bus.read_data), 32'(exp_q.pop_front()));
            step();
        end
        drive(0, 8'h00, 0, 0);
        chk_state("wrap_end", 3'd0, 8'h00, 0, 0);

        // Asynchronous reset between edges with two entries resident.
        drive(1, 8'hA1, 0, 0);
        step();
        drive(1, 8'hB2, 0, 0);
        step();
        drive(0, 8'h00, 0, 0);
        chk("burst count", 32'(count), 32'd2);
        #2 RST = 1'b0;
        #1 chk_state("async_reset", 3'd0, 8'h00, 0, 0);
        step();
        step();
        RST = 1'b1;
        drive(1, 8'hC3, 0, 0);
        step();
        chk_state("after_reset_wr", 3'd1, 8'hC3, 0, 0);
        drive(0, 8'h00, 1, 0);
        step();
        drive(0, 8'h00, 0, 0);
        chk_state("after_reset_rd", 3'd0, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parametrised synchronous FIFO; next generation of the fixed two-entry handshake FIFOs used between matrix-computation stages.
- Generalises data width and depth; adds occupancy count, programmable almost-full/almost-empty flags, synchronous clear, and sticky overflow/underflow error flags.
- Keeps the write/read enable-ready handshake so it drops into existing Input/Output FIFO positions without changing the surrounding handshake logic.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1).

Ports:
- CLK  input  1  clock; all state on rising edge.
- RST  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush, active-high.
- write_enable  input  1  enqueue request.
- write_data  input  WIDTH  enqueue data.
- write_ready  output  1  FIFO not full.
- read_enable  input  1  dequeue request.
- read_ready  output  1  FIFO not empty; read_data valid.
- read_data  output  WIDTH  head entry (first-word fall-through).
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (RST low, asynchronous, takes effect without a clock edge): wr_ptr=0, rd_ptr=0, count=0, write_ready=1, read_ready=0, read_data=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Storage array is not reset. Reset asserted mid-operation discards all contents immediately.
- Storage: DEPTH x WIDTH register array. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in a count register (no pointer-difference logic).
- Accepted write (write_enable & write_ready): mem[wr_ptr] <= write_data; wr_ptr increments.
- Accepted read (read_enable & read_ready): rd_ptr increments.
- Count update: +1 for accepted write only; -1 for accepted read only; unchanged when both are accepted or neither.
- write_ready = (count != DEPTH). read_ready = (count != 0). Both are derived from registered count; neither depends combinationally on write_enable or read_enable.
- Full FIFO: write is rejected even if a read is accepted in the same cycle, matching the existing two-entry FIFO. Writer retries next cycle.
- Empty FIFO: read is rejected; a same-cycle write is accepted. No bypass path.
- Latency: data written at edge t has read_ready=1 and read_data valid after edge t; first read accepted at edge t+1.
- read_data = mem[rd_ptr] when count != 0, else 0. Driven from registers, combinational mux only.
- overflow sets on write_enable & ~write_ready; underflow sets on read_enable & ~read_ready. Both hold until reset or clear.
- almost_full and almost_empty are combinational from registered count.
- clear (synchronous): pointers, count, overflow and underflow go to 0 at the edge. Clear overrides any same-cycle write or read, and those are not flagged. Outputs then match the reset state.
- No X may propagate to any output after reset.

Test Plan:
- Reset/idle (WIDTH=8, DEPTH=4): pulse RST low mid-clock -> outputs immediately take reset values: write_ready=1, read_ready=0, count=0, almost_empty=1, read_data=0.
- Fill/drain: write 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Fill -> count 1,2,3,4; almost_full at count 3; write_ready=0 at count 4.
  - 5th write 0x55 -> rejected, overflow=1, count stays 4.
  - Drain -> read_data order 0x11,0x22,0x33,0x44; read_ready=0 after the 4th read.
- Simultaneous ops at count=2 (write 0xA0 + read) -> count stays 2, order preserved. At count=4 (write + read) -> read accepted, write rejected, count=3, overflow=1. At count=0 (write + read) -> write accepted, count=1, underflow=1.
- Wrap-around: 10 write/read pairs with 2 entries resident -> pointers wrap ≥2 times; output sequence equals input sequence exactly (scoreboard).
- Clear: with count=3 and overflow=1, assert clear with write_enable=1 -> next cycle count=0, overflow=0, read_ready=0; write not stored.
- Async reset mid-burst: drop RST while count=2 between clock edges -> count=0 and read_ready=0 before the next edge; after release, the first write is read back correctly.
